// File: rtl/trigger_counter_bank.sv
// trigger_counter_bank
//   Multi-channel trigger counter bank for the MOPS-Hub trigger/readout path.
//   Each channel counts trigger requests (level or rising-edge), either wraps
//   or saturates at the maximum count, and keeps a sticky overflow flag.
//   A req/ack handshake returns an atomic snapshot of one selected channel.
//   The snapshot can optionally clear that channel when it is captured.
//
// Ports
//   clk       system clock, posedge
//   rst       synchronous reset, active-low
//   cnt_en    global count enable (clears still act when low)
//   trig_in   per-channel trigger request
//   clr_ch    per-channel clear of counter and overflow flag
//   rd_req    readout request, held until rd_valid is seen
//   rd_sel    channel to read, sampled at capture
//   rd_ack    consumer accepts the snapshot
//   rd_valid  snapshot outputs valid
//   rd_count  captured count
//   rd_ovf    captured overflow flag
//   rd_err    rd_sel was out of range at capture
//   any_ovf   registered OR of all live overflow flags
module trigger_counter_bank #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = 2,
    parameter bit SATURATE    = 1'b0,
    parameter bit EDGE_MODE   = 1'b0,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic [N_CH-1:0]  trig_in,
    input  logic [N_CH-1:0]  clr_ch,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             rd_ack,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_ovf,
    output logic             rd_err,
    output logic             any_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;
    logic [N_CH-1:0]  trig_q;
    logic [N_CH-1:0]  inc;
    logic [N_CH-1:0]  cor_clr;
    logic             cap;
    logic             sel_ok;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_ovf;

    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_count_q;
    logic             rd_ovf_q;
    logic             rd_err_q;
    logic             any_ovf_q;

    always_comb begin
        cap     = (state_q == ST_IDLE) && rd_req;
        sel_ok  = 32'(rd_sel) < 32'(N_CH);
        sel_cnt = '0;
        sel_ovf = 1'b0;
        cor_clr = '0;
        // An out-of-range select matches no channel, so it reads zero and
        // never triggers a clear-on-read.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(rd_sel) == i) begin
                sel_cnt    = cnt_q[i];
                sel_ovf    = ovf_q[i];
                cor_clr[i] = CLR_ON_READ && cap;
            end
        end

        inc = EDGE_MODE ? ({N_CH{cnt_en}} & trig_in & ~trig_q)
                        : ({N_CH{cnt_en}} & trig_in);

        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr_ch[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (cor_clr[i]) begin
                // Snapshot takes the old value; a coincident increment is
                // kept by restarting the counter at one.
                cnt_d[i] = inc[i] ? CNT_W'(1) : '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SATURATE ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q     <= '0;
            trig_q    <= '0;
            any_ovf_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q     <= ovf_d;
            trig_q    <= trig_in;
            any_ovf_q <= |ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_count_q <= '0;
            rd_ovf_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_req) begin
                        rd_count_q <= sel_cnt;
                        rd_ovf_q   <= sel_ovf;
                        rd_err_q   <= !sel_ok;
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rd_ack) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A request still held from the last read must drop
                    // before another capture is allowed.
                    if (!rd_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    rd_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_count = rd_count_q;
    assign rd_ovf   = rd_ovf_q;
    assign rd_err   = rd_err_q;
    assign any_ovf  = any_ovf_q;

endmodule

// File: tb/tb_trigger_counter_bank.sv
// tb_trigger_counter_bank
//   Scoreboard bench for trigger_counter_bank. Two instances:
//     dut_a: N_CH=4, CNT_W=8, level mode, wrap, no clear-on-read
//     dut_b: N_CH=3, CNT_W=4, edge mode, saturate, clear-on-read
//   Reads push hand-computed expectations into a per-instance queue; a
//   monitor pops and compares on each rising rd_valid.
module tb_trigger_counter_bank;

    logic       clk;
    logic       rst;
    logic [1:0] cnt_en;
    logic [3:0] trig_in [2];
    logic [3:0] clr_ch  [2];
    logic [1:0] rd_req;
    logic [1:0] rd_sel  [2];
    logic [1:0] rd_ack;
    logic [1:0] rd_valid;
    logic [1:0] rd_ovf;
    logic [1:0] rd_err;
    logic [1:0] any_ovf;
    logic [7:0] a_rd_count;
    logic [3:0] b_rd_count;
    logic [1:0] prev_v;

    typedef struct {
        int cnt;
        int ovf;
        int err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    trigger_counter_bank #(
        .N_CH(4), .CNT_W(8), .SEL_W(2),
        .SATURATE(1'b0), .EDGE_MODE(1'b0), .CLR_ON_READ(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .cnt_en(cnt_en[0]),
        .trig_in(trig_in[0]), .clr_ch(clr_ch[0]),
        .rd_req(rd_req[0]), .rd_sel(rd_sel[0]), .rd_ack(rd_ack[0]),
        .rd_valid(rd_valid[0]), .rd_count(a_rd_count), .rd_ovf(rd_ovf[0]),
        .rd_err(rd_err[0]), .any_ovf(any_ovf[0])
    );

    trigger_counter_bank #(
        .N_CH(3), .CNT_W(4), .SEL_W(2),
        .SATURATE(1'b1), .EDGE_MODE(1'b1), .CLR_ON_READ(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .cnt_en(cnt_en[1]),
        .trig_in(trig_in[1][2:0]), .clr_ch(clr_ch[1][2:0]),
        .rd_req(rd_req[1]), .rd_sel(rd_sel[1]), .rd_ack(rd_ack[1]),
        .rd_valid(rd_valid[1]), .rd_count(b_rd_count), .rd_ovf(rd_ovf[1]),
        .rd_err(rd_err[1]), .any_ovf(any_ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int d, input int c, input int o, input int e);
        exp_t x;
        x.cnt = c;
        x.ovf = o;
        x.err = e;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic check_pop(input int d, input int c, input int o, input int e);
        exp_t x;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid dut%0d: got count %0d, expected no snapshot", d, c);
        end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            chk($sformatf("rd_count dut%0d", d), 32'(c), 32'(x.cnt));
            chk($sformatf("rd_ovf dut%0d", d),   32'(o), 32'(x.ovf));
            chk($sformatf("rd_err dut%0d", d),   32'(e), 32'(x.err));
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid[0] && !prev_v[0])
            check_pop(0, 32'(a_rd_count), 32'(rd_ovf[0]), 32'(rd_err[0]));
        if (rd_valid[1] && !prev_v[1])
            check_pop(1, 32'(b_rd_count), 32'(rd_ovf[1]), 32'(rd_err[1]));
        prev_v <= rd_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Level pulse: trigger held high for n clock edges.
    task automatic pulse(input int d, input int ch, input int n);
        trig_in[d][ch] = 1'b1;
        repeat (n) tick();
        trig_in[d][ch] = 1'b0;
    endtask

    // n separate one-cycle-high pulses.
    task automatic edges(input int d, input int ch, input int n);
        repeat (n) begin
            trig_in[d][ch] = 1'b1;
            tick();
            trig_in[d][ch] = 1'b0;
            tick();
        end
    endtask

    task automatic do_read(input int d, input int sel, input int ec, input int eo,
                           input int ee, input int hold);
        int n;
        push_exp(d, ec, eo, ee);
        rd_sel[d] = 2'(sel);
        rd_req[d] = 1'b1;
        tick();
        n = 0;
        while (!rd_valid[d] && n < 8) begin
            tick();
            n++;
        end
        if (!rd_valid[d]) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_timeout dut%0d: got rd_valid 0, expected 1", d);
            if (d == 0 && q0.size() > 0) void'(q0.pop_back());
            if (d == 1 && q1.size() > 0) void'(q1.pop_back());
        end
        rd_ack[d] = 1'b1;
        tick();
        rd_ack[d] = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk($sformatf("rd_valid_held_req dut%0d", d), 32'(rd_valid[d]), 32'd0);
            tick();
        end
        rd_req[d] = 1'b0;
        tick();
    endtask

    initial begin
        rst    = 1'b0;
        cnt_en = 2'b00;
        rd_req = 2'b00;
        rd_ack = 2'b00;
        prev_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            trig_in[d] = '0;
            clr_ch[d]  = '0;
            rd_sel[d]  = '0;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset rd_valid dut%0d", d), 32'(rd_valid[d]), 32'd0);
            chk($sformatf("reset rd_ovf dut%0d", d),   32'(rd_ovf[d]),   32'd0);
            chk($sformatf("reset rd_err dut%0d", d),   32'(rd_err[d]),   32'd0);
            chk($sformatf("reset any_ovf dut%0d", d),  32'(any_ovf[d]),  32'd0);
        end
        chk("reset rd_count dut0", 32'(a_rd_count), 32'd0);
        chk("reset rd_count dut1", 32'(b_rd_count), 32'd0);
        tick();
        rst    = 1'b1;
        cnt_en = 2'b11;
        tick();

        // dut_a: level counting, freeze, clear priority
        pulse(0, 0, 5);
        do_read(0, 0, 5, 0, 0, 0);
        do_read(0, 1, 0, 0, 0, 0);
        do_read(0, 3, 0, 0, 0, 0);
        cnt_en[0] = 1'b0;
        pulse(0, 1, 4);
        cnt_en[0] = 1'b1;
        do_read(0, 1, 0, 0, 0, 0);
        trig_in[0][1] = 1'b1;
        repeat (3) tick();
        clr_ch[0][1] = 1'b1;
        tick();
        clr_ch[0][1]  = 1'b0;
        trig_in[0][1] = 1'b0;
        tick();
        do_read(0, 1, 0, 0, 0, 0);
        do_read(0, 0, 5, 0, 0, 0);

        // dut_a: max count without overflow, then wrap with overflow
        pulse(0, 3, 255);
        tick();
        @(negedge clk);
        chk("any_ovf_at_max dut0", 32'(any_ovf[0]), 32'd0);
        do_read(0, 3, 255, 0, 0, 0);
        pulse(0, 2, 257);
        tick();
        tick();
        @(negedge clk);
        chk("any_ovf_after_wrap dut0", 32'(any_ovf[0]), 32'd1);
        do_read(0, 2, 1, 1, 0, 0);
        do_read(0, 3, 255, 0, 0, 0);
        clr_ch[0][2] = 1'b1;
        tick();
        clr_ch[0][2] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("any_ovf_after_clr dut0", 32'(any_ovf[0]), 32'd0);
        do_read(0, 2, 0, 0, 0, 0);

        // dut_a: request held across ack gives one capture only
        do_read(0, 0, 5, 0, 0, 3);
        do_read(0, 0, 5, 0, 0, 0);

        // dut_b: edge counting with clear-on-read
        repeat (3) begin
            trig_in[1][2] = 1'b1;
            repeat (10) tick();
            trig_in[1][2] = 1'b0;
            repeat (2) tick();
        end
        do_read(1, 2, 3, 0, 0, 0);
        do_read(1, 2, 0, 0, 0, 0);

        // dut_b: saturation
        edges(1, 0, 17);
        @(negedge clk);
        chk("any_ovf_saturate dut1", 32'(any_ovf[1]), 32'd1);
        do_read(1, 0, 15, 1, 0, 0);
        @(negedge clk);
        chk("any_ovf_after_cor dut1", 32'(any_ovf[1]), 32'd0);
        do_read(1, 0, 0, 0, 0, 0);

        // dut_b: clear-on-read with coincident increment
        edges(1, 2, 7);
        trig_in[1][2] = 1'b1;
        do_read(1, 2, 7, 0, 0, 0);
        trig_in[1][2] = 1'b0;
        tick();
        do_read(1, 2, 1, 0, 0, 0);

        // dut_b: out-of-range select neither reads nor clears
        edges(1, 0, 2);
        do_read(1, 3, 0, 0, 1, 0);
        do_read(1, 0, 2, 0, 0, 0);

        // dut_b: clear beats trigger; edge history tracks while disabled
        edges(1, 1, 2);
        trig_in[1][1] = 1'b1;
        clr_ch[1][1]  = 1'b1;
        tick();
        clr_ch[1][1]  = 1'b0;
        trig_in[1][1] = 1'b0;
        tick();
        cnt_en[1]     = 1'b0;
        trig_in[1][1] = 1'b1;
        tick();
        tick();
        cnt_en[1] = 1'b1;
        tick();
        tick();
        trig_in[1][1] = 1'b0;
        tick();
        do_read(1, 1, 0, 0, 0, 0);

        // dut_a: reset while a snapshot is held
        pulse(0, 0, 4);
        pulse(0, 2, 256);
        tick();
        @(negedge clk);
        chk("any_ovf_before_rst dut0", 32'(any_ovf[0]), 32'd1);
        tick();
        push_exp(0, 9, 0, 0);
        rd_sel[0] = 2'd0;
        rd_req[0] = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        rd_req[0] = 1'b0;
        @(negedge clk);
        chk("rd_valid_after_rst dut0", 32'(rd_valid[0]), 32'd0);
        chk("any_ovf_after_rst dut0",  32'(any_ovf[0]),  32'd0);
        chk("rd_count_after_rst dut0", 32'(a_rd_count),  32'd0);
        tick();
        do_read(0, 0, 0, 0, 0, 0);
        do_read(0, 2, 0, 0, 0, 0);

        // dut_a: disabled counting ignores triggers
        cnt_en[0]  = 1'b0;
        trig_in[0] = 4'hF;
        repeat (3) tick();
        trig_in[0] = 4'h0;
        cnt_en[0]  = 1'b1;
        tick();
        do_read(0, 0, 0, 0, 0, 0);
        do_read(0, 3, 0, 0, 0, 0);

        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) tick();
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
